// File: rtl/picomips_seq_ctrl.sv
// picomips_seq_ctrl: multi-cycle PC/phase sequencer driving RAM, ROM, GPR and ALU strobes
module picomips_seq_ctrl #(
    parameter int PC_W    = 4,
    parameter int ROM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [7:0]      instr,
    input  logic            alu_sign,
    output logic [PC_W-1:0] pc,
    output logic            ram_wr_en,
    output logic            ram_rd_en,
    output logic [1:0]      ram_addr,
    output logic            rom_rd_en,
    output logic            gpr_wr_en,
    output logic [2:0]      gpr_addr,
    output logic            alu_en,
    output logic [2:0]      alu_code,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [7:0]      retired
);
    localparam int CW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, WRAM, RRAM, ROMRD, WB, EXEC, BR, HALT} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, target;
    logic [7:0]      ir_q, ir_d, ret_q, ret_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d, ill_q, ill_d, done, taken;
    assign pc_inc = pc_q + 1'b1;
    assign target = PC_W'(ir_q[3:0]);
    assign taken  = ir_q[7:5] == 3'b101 || (ir_q[7:5] == 3'b100 && sign_q);
    // Next-state: DECODE steers on the live instr bus because ir is only loaded at its end;
    // every op state that ends an instruction funnels through the shared retire path.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        ill_d   = ill_q;
        done    = 1'b0;
        case (state_q)
            IDLE:   state_d = run ? FETCH : IDLE;
            FETCH:  state_d = DECODE;
            DECODE: begin
                ir_d = instr;
                case (instr[7:5])
                    3'b001:         state_d = WRAM;
                    3'b010:         state_d = RRAM;
                    3'b011:         state_d = EXEC;
                    3'b100, 3'b101: state_d = BR;
                    3'b111: begin
                        state_d = HALT;
                        ret_d   = ret_q + 8'd1;
                    end
                    default: begin
                        state_d = FETCH;
                        ret_d   = ret_q + 8'd1;
                        pc_d    = pc_inc;
                        ill_d   = ill_q | (instr[7:5] == 3'b110);
                    end
                endcase
            end
            RRAM: begin
                state_d = ROMRD;
                cnt_d   = CW'(ROM_LAT - 1);
            end
            ROMRD: begin
                state_d = cnt_q == '0 ? WB : ROMRD;
                cnt_d   = cnt_q - 1'b1;
            end
            EXEC: begin
                sign_d = alu_sign;
                done   = 1'b1;
            end
            WRAM, WB, BR: done = 1'b1;
            HALT:         state_d = HALT;
            default:      state_d = IDLE;
        endcase
        if (done) begin
            state_d = FETCH;
            ret_d   = ret_q + 8'd1;
            pc_d    = (state_q == BR && taken) ? target : pc_inc;
        end
    end
    // State and architectural registers; async reset clears strobes immediately via state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            ill_q   <= ill_d;
        end
    end
    assign pc        = pc_q;
    assign ram_wr_en = state_q == WRAM;
    assign ram_rd_en = state_q == RRAM;
    assign rom_rd_en = state_q == ROMRD;
    assign gpr_wr_en = state_q == WB;
    assign alu_en    = state_q == EXEC;
    assign ram_addr  = ir_q[1:0];
    assign gpr_addr  = ir_q[4:2];
    assign alu_code  = ir_q[4:2];
    assign busy      = state_q != IDLE && state_q != HALT;
    assign halted    = state_q == HALT;
    assign illegal   = ill_q;
    assign retired   = ret_q;
endmodule

// File: tb/tb_picomips_seq_ctrl.sv
// tb_picomips_seq_ctrl: ISA-model scoreboard bench for the PICOMIPS sequencer
module tb_picomips_seq_ctrl;
    localparam int LAT = 2;
    logic       clk = 1'b0, rst_n = 1'b1, run = 1'b0, alu_sign;
    logic [7:0] instr = 8'h00;
    logic [3:0] pc;
    logic       ram_wr_en, ram_rd_en, rom_rd_en, gpr_wr_en, alu_en, busy, halted, illegal;
    logic [1:0] ram_addr;
    logic [2:0] gpr_addr, alu_code;
    logic [7:0] retired;
    logic [7:0] mem [16];

    typedef struct {
        logic [3:0] pc;
        logic [7:0] ret;
        int         cyc, wr, rd, rom, gpr, alu;
        logic [1:0] ra;
        logic [2:0] ga, ac;
        logic       ill, hlt;
    } rec_t;
    rec_t q[$];
    rec_t me;
    int checks = 0, errors = 0;

    picomips_seq_ctrl #(.PC_W(4), .ROM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .alu_sign(alu_sign),
        .pc(pc), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .rom_rd_en(rom_rd_en), .gpr_wr_en(gpr_wr_en), .gpr_addr(gpr_addr),
        .alu_en(alu_en), .alu_code(alu_code), .busy(busy), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;
    // synchronous instruction memory and an ALU whose sign is the low code bit
    always @(posedge clk) instr <= mem[pc];
    assign alu_sign = alu_code[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ISA reference: walks mem from pc 0 and pushes one record per retired instruction
    task automatic model(input int maxn, output int tot);
        logic [3:0] p = 0;
        logic [7:0] r = 0;
        logic       s = 0, il = 0;
        tot = 0;
        for (int n = 0; n < maxn; n++) begin
            logic [7:0] i;
            logic [2:0] op;
            rec_t e;
            i = mem[p];
            op = i[7:5];
            e = '{default: 0};
            e.cyc = 2;
            r++;
            case (op)
                3'd1: begin e.cyc = 3; e.wr = 1; e.ra = i[1:0]; end
                3'd2: begin e.cyc = 4 + LAT; e.rd = 1; e.rom = LAT; e.gpr = 1; e.ra = i[1:0]; e.ga = i[4:2]; end
                3'd3: begin e.cyc = 3; e.alu = 1; e.ac = i[4:2]; s = i[2]; end
                3'd4, 3'd5: e.cyc = 3;
                3'd6: il = 1;
                default: ;
            endcase
            p = (op == 3'd7) ? p : (op == 3'd5 || (op == 3'd4 && s)) ? i[3:0] : p + 4'd1;
            e.pc = p;
            e.ret = r;
            e.ill = il;
            e.hlt = op == 3'd7;
            tot += e.cyc;
            q.push_back(e);
            if (op == 3'd7) break;
        end
    endtask

    int c_cyc, c_wr, c_rd, c_rom, c_gpr, c_alu, c_multi;
    logic [1:0] c_ra;
    logic [2:0] c_ga, c_ac;
    logic [7:0] prev;
    // monitor: accumulates per-instruction activity, compares against the scoreboard on each retire
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev = 0; c_cyc = 0; c_wr = 0; c_rd = 0; c_rom = 0; c_gpr = 0; c_alu = 0; c_multi = 0;
            c_ra = 0; c_ga = 0; c_ac = 0;
        end else begin
            if (retired !== prev) begin
                prev = retired;
                if (q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("pc", pc, me.pc);
                    chk("retired", retired, me.ret);
                    chk("cycles", c_cyc, me.cyc);
                    chk("ram_wr_cycles", c_wr, me.wr);
                    chk("ram_rd_cycles", c_rd, me.rd);
                    chk("rom_rd_cycles", c_rom, me.rom);
                    chk("gpr_wr_cycles", c_gpr, me.gpr);
                    chk("alu_en_cycles", c_alu, me.alu);
                    chk("ram_addr", c_ra, me.ra);
                    chk("gpr_addr", c_ga, me.ga);
                    chk("alu_code", c_ac, me.ac);
                    chk("illegal", illegal, me.ill);
                    chk("halted", halted, me.hlt);
                    chk("strobe_overlap", c_multi, 0);
                end
                c_cyc = 0; c_wr = 0; c_rd = 0; c_rom = 0; c_gpr = 0; c_alu = 0; c_multi = 0;
                c_ra = 0; c_ga = 0; c_ac = 0;
            end
            c_cyc += int'(busy);
            c_wr  += int'(ram_wr_en);
            c_rd  += int'(ram_rd_en);
            c_rom += int'(rom_rd_en);
            c_gpr += int'(gpr_wr_en);
            c_alu += int'(alu_en);
            if (ram_wr_en || ram_rd_en) c_ra = ram_addr;
            if (gpr_wr_en) c_ga = gpr_addr;
            if (alu_en) c_ac = alu_code;
            if (int'(ram_wr_en) + int'(ram_rd_en) + int'(rom_rd_en) + int'(gpr_wr_en) + int'(alu_en) > 1) c_multi++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    // runs a HALT-terminated program; halt latency counts edges from the run-sampling edge
    task automatic run_halting();
        int tot, n;
        model(64, tot);
        @(negedge clk);
        run = 1'b1;
        n = 0;
        for (int b = 0; b < tot + 50; b++) begin
            @(posedge clk);
            #1 run = 1'b0;
            n++;
            if (halted) break;
        end
        chk("halt_latency", n, tot + 1);
        @(negedge clk);
        #1 chk("queue_drained", q.size(), 0);
    endtask

    // runs a looping program for maxn instructions, then stops it with reset
    task automatic run_loop(input int maxn);
        int tot;
        model(maxn, tot);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int b = 0; b < tot + 50; b++) begin
            @(negedge clk);
            #1 if (q.size() == 0) break;
        end
        chk("loop_drained", q.size(), 0);
        do_reset();
    endtask

    initial begin
        fill(8'hE0);
        #1 rst_n = 1'b0;
        #1 chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired", retired, 0);
        chk("rst_strobes", {ram_wr_en, ram_rd_en, rom_rd_en, gpr_wr_en, alu_en}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_run_pc", pc, 0);
        chk("idle_busy", busy, 0);

        // NOP, HALT
        fill(8'hE0);
        mem[0] = 8'h00;
        run_halting();
        chk("halt_pc", pc, 1);

        // STI, LDK, ALU(sign=1), BRS taken, ALU(sign=0), BRS not taken, reserved, HALT
        do_reset();
        fill(8'hE0);
        mem[0] = 8'h23; mem[1] = 8'h49; mem[2] = 8'h64; mem[3] = 8'h85;
        mem[5] = 8'h68; mem[6] = 8'h85; mem[7] = 8'hC0; mem[8] = 8'hE0;
        run_halting();
        @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b0;
        chk("halt_absorbing", halted, 1);
        chk("halt_not_busy", busy, 0);
        chk("halt_pc_hold", pc, 8);
        chk("illegal_sticky", illegal, 1);

        // JMP at pc 15 back to 0, long enough to wrap the retire counter
        do_reset();
        fill(8'h00);
        mem[15] = 8'hA0;
        run_loop(300);

        // straight NOPs wrap pc 15 -> 0
        fill(8'h00);
        run_loop(20);

        // reserved then LDK; reset lands during ROM read
        fill(8'hE0);
        mem[0] = 8'hC0; mem[1] = 8'h49;
        begin
            int tot;
            bit seen;
            model(1, tot);
            @(negedge clk);
            run = 1'b1;
            @(negedge clk);
            run = 1'b0;
            seen = 0;
            for (int b = 0; b < 50; b++) begin
                @(negedge clk);
                #1 if (rom_rd_en) begin seen = 1; break; end
            end
            chk("rom_rd_seen", seen, 1);
            chk("pre_reset_illegal", illegal, 1);
            chk("pre_reset_queue", q.size(), 0);
            #1 rst_n = 1'b0;
            #1 chk("async_strobes", {ram_wr_en, ram_rd_en, rom_rd_en, gpr_wr_en, alu_en}, 0);
            chk("async_busy", busy, 0);
            chk("async_pc", pc, 0);
            chk("async_retired", retired, 0);
            chk("async_illegal", illegal, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("post_reset_idle", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
